// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control FSM driving every DataPath strobe.
// Optional `SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011,
    parameter logic [4:0] AND_OP = 5'b00101,
    parameter logic [4:0] OR_OP  = 5'b00110
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        PC_out,
    output logic        ZHigh_out,
    output logic        ZLow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        C_out,
    output logic        MDR_out,
    output logic        in_port_out,
    output logic        BA_out,
    output logic        R_out,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        Z_enable,
    output logic        Y_enable,
    output logic        PC_enable,
    output logic        LO_enable,
    output logic        HI_enable,
    output logic        IR_enable,
    output logic        R_in,
    output logic        out_port_enable,
    output logic        con_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        RAM_write_enable,
    output logic [4:0]  opcode,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t state_q, state_d, done_st;

    logic [4:0] op;
    logic is_ld, is_ldi, is_st, is_r, is_i, is_br, is_halt, is_mem;
    logic [4:0] imm_op;
    logic unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_ld     = (op == 5'b00000);
    assign is_ldi    = (op == 5'b00001);
    assign is_st     = (op == 5'b00010);
    assign is_r      = (op >= 5'b00011) && (op <= 5'b00110);
    assign is_i      = (op >= 5'b01001) && (op <= 5'b01011);
    assign is_br     = (op == 5'b10011);
    assign is_halt   = (op == 5'b11011);
    assign is_mem    = is_ld || is_ldi || is_st;

    always_comb begin
        unique case (1'b1)
            (op == 5'b01010): imm_op = AND_OP;
            (op == 5'b01011): imm_op = OR_OP;
            default:          imm_op = ADD_OP;
        endcase
    end

`ifdef SINGLE_STEP_EN
    assign done_st = S_PAUSE;
`else
    assign done_st = S_T0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_mem || is_r || is_i || is_br)
                    state_d = S_T3;
                else
                    state_d = done_st;
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (is_ldi || is_r || is_i) ? done_st : S_T6;
            S_T6:    state_d = is_br ? done_st : S_T7;
            S_T7:    state_d = done_st;
            S_HALT:  state_d = S_HALT;
`ifdef SINGLE_STEP_EN
            S_PAUSE: state_d = step ? S_T0 : S_PAUSE;
`endif
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge Clock or posedge clr) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    // Strobes decode from the registered state, so clr clears them without a clock.
    always_comb begin
        {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out,
         in_port_out, BA_out, R_out} = '0;
        {MAR_enable, MDR_enable, Z_enable, Y_enable, PC_enable, LO_enable,
         HI_enable, IR_enable, R_in, out_port_enable, con_in} = '0;
        {Gra, Grb, Grc, IncPC, Read, RAM_write_enable} = '0;
        opcode = 5'b00000;
        run    = (state_q != S_RESET) && (state_q != S_HALT);
        unique case (state_q)
            S_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; end
            S_T1: begin Read = 1'b1; MDR_enable = 1'b1; end
            S_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; end
            S_T3: begin
                if (is_br) begin
                    Gra = 1'b1; R_out = 1'b1; con_in = 1'b1;
                end else begin
                    Grb = 1'b1; Y_enable = 1'b1;
                    BA_out = is_mem;
                    R_out  = !is_mem;
                end
            end
            S_T4: begin
                if (is_br) begin
                    PC_out = 1'b1; Y_enable = 1'b1;
                end else if (is_r) begin
                    Grc = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op;
                end else begin
                    C_out = 1'b1; Z_enable = 1'b1;
                    opcode = is_i ? imm_op : ADD_OP;
                end
            end
            S_T5: begin
                if (is_br) begin
                    C_out = 1'b1; Z_enable = 1'b1; opcode = ADD_OP;
                end else if (is_ld || is_st) begin
                    ZLow_out = 1'b1; MAR_enable = 1'b1;
                end else begin
                    ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end
            end
            S_T6: begin
                if (is_br) begin
                    ZLow_out = 1'b1; PC_enable = CON_FF;
                end else if (is_st) begin
                    Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1;
                end else begin
                    Read = 1'b1; MDR_enable = 1'b1;
                end
            end
            S_T7: begin
                if (is_st) begin
                    RAM_write_enable = 1'b1;
                end else begin
                    MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a per-opcode strobe table model.
// Works with and without `SINGLE_STEP_EN defined.
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic clr, CON_FF, step;
    logic [31:0] IR;
    logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out;
    logic in_port_out, BA_out, R_out, MAR_enable, MDR_enable, Z_enable;
    logic Y_enable, PC_enable, LO_enable, HI_enable, IR_enable, R_in;
    logic out_port_enable, con_in, Gra, Grb, Grc, IncPC, Read;
    logic RAM_write_enable, run;
    logic [4:0] opcode;
    logic [32:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .clr(clr), .IR(IR), .CON_FF(CON_FF),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out),
        .HI_out(HI_out), .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out),
        .in_port_out(in_port_out), .BA_out(BA_out), .R_out(R_out),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .Z_enable(Z_enable),
        .Y_enable(Y_enable), .PC_enable(PC_enable), .LO_enable(LO_enable),
        .HI_enable(HI_enable), .IR_enable(IR_enable), .R_in(R_in),
        .out_port_enable(out_port_enable), .con_in(con_in),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
        .RAM_write_enable(RAM_write_enable), .opcode(opcode), .run(run)
    );

    assign obs = {run, opcode, RAM_write_enable, Read, IncPC, Grc, Grb, Gra,
                  con_in, out_port_enable, R_in, IR_enable, HI_enable,
                  LO_enable, PC_enable, Y_enable, Z_enable, MDR_enable,
                  MAR_enable, R_out, BA_out, in_port_out, MDR_out, C_out,
                  LO_out, HI_out, ZLow_out, ZHigh_out, PC_out};

    localparam int PCO = 0, ZLO = 2, CO = 5, MDRO = 6, BAO = 8, RO = 9;
    localparam int MARE = 10, MDRE = 11, ZE = 12, YE = 13, PCE = 14;
    localparam int IRE = 17, RIN = 18, CONIN = 20, GRA = 21, GRB = 22;
    localparam int GRC = 23, INC = 24, RD = 25, WE = 26, RUN = 32;

    // Instruction lengths in clocks, straight from the latency table.
    function automatic int latency(input logic [4:0] op);
        if (op == 5'd0 || op == 5'd2) return 8;
        if (op == 5'b10011) return 7;
        if (op == 5'd1 || (op >= 5'd3 && op <= 5'd6) || (op >= 5'd9 && op <= 5'd11))
            return 6;
        return 3;
    endfunction

    function automatic logic [32:0] model(input logic [4:0] op, input int t,
                                          input logic con);
        logic [32:0] v;
        int e;
        v = '0;
        v[RUN] = 1'b1;
        e = t - 3;
        if (t == 0) begin v[PCO] = 1; v[MARE] = 1; v[INC] = 1; end
        else if (t == 1) begin v[RD] = 1; v[MDRE] = 1; end
        else if (t == 2) begin v[MDRO] = 1; v[IRE] = 1; end
        else if (op <= 5'd2) begin
            case (e)
                0: begin v[GRB] = 1; v[BAO] = 1; v[YE] = 1; end
                1: begin v[CO] = 1; v[ZE] = 1; v[31:27] = 5'd3; end
                2: if (op == 5'd1) begin v[ZLO] = 1; v[GRA] = 1; v[RIN] = 1; end
                   else begin v[ZLO] = 1; v[MARE] = 1; end
                3: if (op == 5'd0) begin v[RD] = 1; v[MDRE] = 1; end
                   else begin v[GRA] = 1; v[RO] = 1; v[MDRE] = 1; end
                4: if (op == 5'd0) begin v[MDRO] = 1; v[GRA] = 1; v[RIN] = 1; end
                   else v[WE] = 1;
                default: ;
            endcase
        end else if (op == 5'b10011) begin
            case (e)
                0: begin v[GRA] = 1; v[RO] = 1; v[CONIN] = 1; end
                1: begin v[PCO] = 1; v[YE] = 1; end
                2: begin v[CO] = 1; v[ZE] = 1; v[31:27] = 5'd3; end
                3: begin v[ZLO] = 1; v[PCE] = con; end
                default: ;
            endcase
        end else begin
            case (e)
                0: begin v[GRB] = 1; v[RO] = 1; v[YE] = 1; end
                1: begin
                    v[ZE] = 1;
                    if (op <= 5'd6) begin
                        v[GRC] = 1; v[RO] = 1; v[31:27] = op;
                    end else begin
                        v[CO] = 1;
                        v[31:27] = (op == 5'd9) ? 5'd3 : (op == 5'd10) ? 5'd5 : 5'd6;
                    end
                end
                2: begin v[ZLO] = 1; v[GRA] = 1; v[RIN] = 1; end
                default: ;
            endcase
        end
        return v;
    endfunction

    // Entered and left at 1 ns after a posedge with the DUT in T0.
    task automatic run_instr(input logic [31:0] ir, input logic con,
                             input string name);
        logic [32:0] exp;
        int n;
        IR = ir;
        CON_FF = con;
        n = latency(ir[31:27]);
        for (int t = 0; t < n; t++) begin
            exp = model(ir[31:27], t, con);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s t%0d: got %h expected %h", name, t, obs, exp);
            end
            @(posedge Clock); #1;
        end
`ifdef SINGLE_STEP_EN
        n = $urandom_range(0, 3);
        for (int k = 0; k <= n; k++) begin
            n_checks++;
            if (obs !== 33'h1_0000_0000) begin
                n_fail++;
                $display("FAIL %s pause: got %h expected %h", name, obs,
                         33'h1_0000_0000);
            end
            if (k < n) begin @(posedge Clock); #1; end
        end
        step = 1'b1;
        @(posedge Clock); #1;
        step = 1'b0;
`endif
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (obs !== 33'h0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", name, obs);
        end
    endtask

    task automatic release_reset(input string name);
        @(negedge Clock);
        clr = 1'b0;
        @(posedge Clock); #1;
        n_checks++;
        if (obs !== model(5'd0, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL %s T0: got %h expected %h", name, obs,
                     model(5'd0, 0, 1'b0));
        end
    endtask

    task automatic test_reset();
        #2 check_zero("reset_async");
        @(posedge Clock); #1;
        check_zero("reset_held");
        release_reset("reset_release");
    endtask

    task automatic test_reset_mid_add();
        logic [31:0] ir = 32'h1912_8000;
        IR = ir;
        for (int t = 0; t < 5; t++) begin
            n_checks++;
            if (obs !== model(ir[31:27], t, 1'b0)) begin
                n_fail++;
                $display("FAIL add_pre_reset t%0d: got %h expected %h", t, obs,
                         model(ir[31:27], t, 1'b0));
            end
            if (t < 4) begin @(posedge Clock); #1; end
        end
        #2 clr = 1'b1;
        #1 check_zero("reset_mid_add");
        @(posedge Clock); #1;
        check_zero("reset_mid_add_held");
        release_reset("reset_mid_add_release");
    endtask

    task automatic test_directed();
        run_instr(32'h0900_0045, 1'b0, "ldi");
        run_instr(32'h1180_0067, 1'b1, "st");
        run_instr(32'h9980_0005, 1'b0, "br_con0");
        run_instr(32'h9980_0005, 1'b1, "br_con1");
        run_instr(32'h2991_8000, 1'b0, "and");
        run_instr(32'h0000_0010, 1'b0, "ld");
        run_instr(32'h5000_0003, 1'b0, "andi");
        run_instr(32'hD000_0000, 1'b0, "nop");
    endtask

    task automatic test_random();
        logic [4:0] ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                 5'd9, 5'd10, 5'd11, 5'd19, 5'd26, 5'd0};
        logic [31:0] ir;
        for (int i = 0; i < 60; i++) begin
            ir = $urandom;
            if (i % 4 == 3) ir[31:27] = 5'($urandom_range(0, 31));
            else ir[31:27] = ops[$urandom_range(0, 11)];
            if (ir[31:27] == 5'b11011) ir[31:27] = 5'b11010;
            run_instr(ir, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_halt();
        IR = 32'hD800_0000;
        for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (obs !== model(5'b11011, t, 1'b0)) begin
                n_fail++;
                $display("FAIL halt_fetch t%0d: got %h expected %h", t, obs,
                         model(5'b11011, t, 1'b0));
            end
            @(posedge Clock); #1;
        end
        IR = $urandom;
        for (int k = 0; k < 20; k++) begin
            check_zero("halt_hold");
            @(posedge Clock); #1;
        end
        clr = 1'b1;
        #1 check_zero("halt_clr");
        release_reset("halt_release");
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        run_instr(32'hD000_0000, 1'b0, "step_nop");
        run_instr(32'h0900_0045, 1'b0, "step_ldi");
    endtask
`endif

    initial begin
        clr = 1'b1;
        IR = '0;
        CON_FF = 1'b0;
        step = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid_add();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        test_halt();
        run_instr(32'h0900_0045, 1'b0, "ldi_after_halt");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
